mvu_out_fifo: RTL and testbench
===============================

Name: mvu_out_fifo

Overview:
- Downstream neighbour of the per-PE accumulators in the MVAU stream path.
- Captures the PE-parallel accumulator word each time the accumulators assert output valid, and buffers it in a small FIFO.
- Drives it out on an AXI-stream master with full ready/valid backpressure.
- Raises a stall flag so the stream controller can hold do_mvau_stream before the buffer overflows.

Parameters:
- PE, 2, number of processing elements (lanes) per output word
- TDstI, 4, accumulator/output word length per PE
- TO, 8, output bus width; must equal PE*TDstI
- DEPTH, 4, FIFO entries; power of two, at least 2
- AFULL_LVL, 2, occupancy at or above which stall is asserted; 1 <= AFULL_LVL <= DEPTH

Ports:
- aclk  in  1  main clock
- areset  in  1  asynchronous, active-high reset
- in_v  in  1  accumulator output valid (all PEs aligned)
- in_dat  in  TO  accumulator outputs; lane p at [p*TDstI +: TDstI], lane 0 in the LSBs
- stall  out  1  occupancy >= AFULL_LVL; upstream must stop issuing in_v
- overflow  out  1  sticky error: a write was dropped
- m_axis_tvalid  out  1  output word valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  TO  output word
- occupancy  out  $clog2(DEPTH)+1  current entry count

Behaviour:
- Reset: asynchronous, active-high, all outputs and state forced to 0.
  - Outputs: m_axis_tvalid=0, m_axis_tdata=0, stall=0 (given AFULL_LVL>=1), overflow=0, occupancy=0.
  - State: read/write pointers 0, storage contents don't-care.
  - Reset asserted mid-transfer discards all entries; no partial word is ever emitted.
- Write: push = in_v & (occupancy<DEPTH | pop). The word lands at wr_ptr; wr_ptr increments modulo DEPTH.
- Read: pop = m_axis_tvalid & m_axis_tready. rd_ptr increments modulo DEPTH.
- Output is registered, first-word fall-through.
  - A word written at edge N into an empty FIFO gives m_axis_tvalid=1 and that data after edge N.
  - Latency is 1 cycle from in_v to tvalid.
  - No combinational path from in_v or in_dat to m_axis_*.
  - No combinational path from m_axis_tready to stall.
- AXI rules:
  - Once tvalid=1, tdata stays stable until the handshake completes.
  - tvalid never drops without a pop.
  - Back-to-back pops sustain 1 word/cycle.
- Occupancy update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Full (occupancy==DEPTH):
  - in_v with pop in the same cycle: accepted.
  - in_v without pop: word dropped, overflow set to 1 on the next edge.
  - overflow clears only by reset.
- Empty: m_axis_tvalid=0, m_axis_tdata holds its last value (0 after reset). Simultaneous push into an empty FIFO with tready=1 gives no pop that cycle.
- stall is registered from the next-state occupancy, so it rises on the same edge the threshold is reached.
- Wrap-around: pointers are $clog2(DEPTH) bits wide and wrap naturally. Full/empty are decided by occupancy, not by pointer equality.
- Data is passed as raw bits. Lane order is preserved; there is no arithmetic unless the optional feature is enabled.

Optional Feature:
- Macro: MVU_OUT_RELU_EN.
- Defined: at write, each lane is interpreted as a signed TDstI value and replaced by 0 if negative (MSB=1). Zero added latency; the clamp sits on the write path only.
- Undefined: lanes are stored unmodified.
- Occupancy, stall and handshake timing are identical in both builds.

Decomposition:
- Shared package mvau_out_pkg:
  - function f_ptr_w(DEPTH) returning $clog2(DEPTH).
  - typedef-style helper lane-slice function for [p*TDstI +: TDstI].
  - localparam checks for TO==PE*TDstI.
- One natural sub-module, mvu_out_lane_relu: combinational per-lane clamp.
  - Generated PE times under MVU_OUT_RELU_EN.
  - Contains no storage.

Test Plan:
- Reset then single write: in_v=1, in_dat=8'hA5, tready=1 -> next cycle tvalid=1, tdata=8'hA5; the following cycle tvalid=0, occupancy=0.
- Backpressure fill: DEPTH=4, AFULL_LVL=2, tready=0, writes 8'h01..8'h04 -> stall=1 after the 2nd write; occupancy=4; overflow=0. Then tready=1 -> 01,02,03,04 out in order, one per cycle.
- Overflow: full FIFO, tready=0, in_v=1 with 8'hFF -> word dropped, overflow=1 sticky, occupancy stays 4; drained data contains no FF.
- Simultaneous push/pop at full: occupancy=4, tready=1, in_v=1 with 8'h55 -> accepted, occupancy stays 4, overflow=0; 8'h55 emerges last.
- Async reset mid-stream: areset pulsed between edges with 3 entries held -> tvalid, stall and occupancy 0 immediately; the next write appears alone.
- MVU_OUT_RELU_EN with TDstI=4, PE=2: in_dat=8'h9C (lanes C = -4, 9 = -7) -> 8'h00; in_dat=8'h7A (lanes A = -6, 7 = 7) -> 8'h70.

Source files
------------

// File: rtl/mvau_out_pkg.sv
// Shared definitions for the MVAU output FIFO: default geometry, pointer width,
// lane slicing and parameter sanity checks.
package mvau_out_pkg;

    localparam int unsigned MVU_PE    = 2;
    localparam int unsigned MVU_TDSTI = 4;
    localparam int unsigned MVU_TO    = MVU_PE * MVU_TDSTI;

    function automatic int unsigned f_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic logic [MVU_TDSTI-1:0] f_lane(input logic [MVU_TO-1:0] word,
                                                    input int unsigned p);
        return word[p*MVU_TDSTI +: MVU_TDSTI];
    endfunction

    // Bus width must match the lane layout; depth a power of two; threshold in range.
    function automatic bit f_cfg_ok(input int unsigned pe, input int unsigned tdsti,
                                    input int unsigned to, input int unsigned depth,
                                    input int unsigned afull);
        return (to == pe * tdsti) && (depth >= 2) && ((depth & (depth - 1)) == 0)
               && (afull >= 1) && (afull <= depth);
    endfunction

endpackage

// File: rtl/mvu_out_lane_relu.sv
// Combinational clamp of one signed accumulator lane: negative values become zero.
module mvu_out_lane_relu #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] lane,
    output logic [W-1:0] clamped
);

    assign clamped = lane[W-1] ? '0 : lane;

endmodule

// File: rtl/mvu_out_fifo.sv
// Output buffer between the MVAU accumulators and an AXI-stream master, with a
// registered first-word-fall-through head. Optional lane ReLU: MVU_OUT_RELU_EN.
module mvu_out_fifo
    import mvau_out_pkg::*;
#(
    parameter int unsigned PE        = MVU_PE,
    parameter int unsigned TDstI     = MVU_TDSTI,
    parameter int unsigned TO        = MVU_TO,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AFULL_LVL = 2
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       in_v,
    input  logic [TO-1:0]              in_dat,
    output logic                       stall,
    output logic                       overflow,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [TO-1:0]              m_axis_tdata,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PW = f_ptr_w(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);
    localparam bit CFG_OK = f_cfg_ok(PE, TDstI, TO, DEPTH, AFULL_LVL);

    if (!CFG_OK) begin : g_cfg_err
        $error("mvu_out_fifo: inconsistent PE/TDstI/TO/DEPTH/AFULL_LVL");
    end

    logic [TO-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          tvalid_reg, stall_reg, overflow_reg;
    logic [TO-1:0] tdata_reg, tdata_next;
    logic [TO-1:0] wr_data;
    logic          push, pop, head_bypass;

`ifdef MVU_OUT_RELU_EN
    for (genvar gi = 0; gi < PE; gi++) begin : g_relu
        mvu_out_lane_relu #(.W(TDstI)) u_relu (
            .lane    (in_dat[gi*TDstI +: TDstI]),
            .clamped (wr_data[gi*TDstI +: TDstI])
        );
    end
`else
    assign wr_data = in_dat;
`endif

    always_comb begin
        pop         = tvalid_reg & m_axis_tready;
        push        = in_v & ((count_reg < DEPTH_C) | pop);
        count_next  = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push)
            count_next = count_reg - CW'(1);
        wr_ptr_next = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        // The incoming word becomes the head when the FIFO is empty after this pop.
        head_bypass = push & ((count_reg == '0) | ((count_reg == CW'(1)) & pop));
        tdata_next  = tdata_reg;
        if (count_next != '0)
            tdata_next = head_bypass ? wr_data : mem[rd_ptr_next];
    end

    always_ff @(posedge aclk) begin
        if (push)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            tvalid_reg   <= 1'b0;
            tdata_reg    <= '0;
            stall_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            tvalid_reg   <= (count_next != '0);
            tdata_reg    <= tdata_next;
            stall_reg    <= (count_next >= AFULL_C);
            overflow_reg <= overflow_reg | (in_v & ~push);
        end
    end

    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = tdata_reg;
    assign stall         = stall_reg;
    assign overflow      = overflow_reg;
    assign occupancy     = count_reg;

endmodule

// File: tb/tb_mvu_out_fifo.sv
// Scoreboard bench for mvu_out_fifo: expected words are queued when driven and
// compared as the AXI-stream handshake retires them.
module tb_mvu_out_fifo;

    logic       aclk = 1'b0;
    logic       areset;
    logic       in_v;
    logic [7:0] in_dat;
    logic       stall;
    logic       overflow;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] m_axis_tdata;
    logic [2:0] occupancy;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] sb_q[$];
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    always #5 aclk = ~aclk;

    mvu_out_fifo #(.PE(2), .TDstI(4), .TO(8), .DEPTH(4), .AFULL_LVL(2)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .in_v          (in_v),
        .in_dat        (in_dat),
        .stall         (stall),
        .overflow      (overflow),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .occupancy     (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_of(input logic [7:0] d);
        logic [7:0] r;
        r = d;
`ifdef MVU_OUT_RELU_EN
        if (d[3]) r[3:0] = 4'h0;
        if (d[7]) r[7:4] = 4'h0;
`endif
        return r;
    endfunction

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit accepted);
        in_v   = 1'b1;
        in_dat = d;
        if (accepted) sb_q.push_back(exp_of(d));
    endtask

    // Retire handshakes and check AXI hold-stability, sampled on the falling edge.
    always @(negedge aclk or posedge areset) begin
        if (areset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
                check("hold_tdata", 32'(m_axis_tdata), 32'(hold_d));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb_q.size() == 0)
                    check("extra_word_sb_entries", 32'(sb_q.size()), 32'd1);
                else
                    check("tdata", 32'(m_axis_tdata), 32'(sb_q.pop_front()));
                $display("word out %02h", m_axis_tdata);
            end
            hold_v = m_axis_tvalid && !m_axis_tready;
            hold_d = m_axis_tdata;
        end
    end

    initial begin
        int n;
        areset = 1'b1; in_v = 1'b0; in_dat = 8'h00; m_axis_tready = 1'b0;
        repeat (2) cyc();
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        areset = 1'b0;
        cyc();

        // single write, one-cycle latency, tdata holds after draining
        m_axis_tready = 1'b1;
        send(8'hA5, 1'b1);
        cyc();
        in_v = 1'b0;
        check("single_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("single_occ", 32'(occupancy), 32'd1);
        cyc();
        check("single_tvalid_after", 32'(m_axis_tvalid), 32'd0);
        check("single_occ_after", 32'(occupancy), 32'd0);
        check("empty_tdata_hold", 32'(m_axis_tdata), 32'(exp_of(8'hA5)));

        // fill under backpressure
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b1);
            cyc();
            check("fill_occ", 32'(occupancy), 32'(i));
            check("fill_stall", 32'(stall), 32'(i >= 2));
        end
        in_v = 1'b0;
        check("fill_overflow", 32'(overflow), 32'd0);

        // push and pop together while full
        m_axis_tready = 1'b1;
        send(8'h55, 1'b1);
        cyc();
        in_v = 1'b0; m_axis_tready = 1'b0;
        check("fullpp_occ", 32'(occupancy), 32'd4);
        check("fullpp_overflow", 32'(overflow), 32'd0);

        // write into a full FIFO without a pop is dropped
        send(8'hFF, 1'b0);
        cyc();
        in_v = 1'b0;
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_occ", 32'(occupancy), 32'd4);
        cyc();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // drain at one word per cycle
        m_axis_tready = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (m_axis_tvalid && n < 20);
        check("drain_cycles", 32'(n), 32'd4);
        check("drain_occ", 32'(occupancy), 32'd0);
        check("drain_stall", 32'(stall), 32'd0);
        m_axis_tready = 1'b0;

        // asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) begin
            send(8'h10 + 8'(i), 1'b1);
            cyc();
        end
        in_v = 1'b0;
        check("pre_rst_occ", 32'(occupancy), 32'd3);
        @(negedge aclk);
        #2 areset = 1'b1;
        #1;
        check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        sb_q.delete();
        #1 areset = 1'b0;
        cyc();
        m_axis_tready = 1'b1;
        send(8'h3C, 1'b1);
        cyc();
        in_v = 1'b0;
        check("post_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("post_rst_occ", 32'(occupancy), 32'd1);
        cyc();
        check("post_rst_alone", 32'(m_axis_tvalid), 32'd0);

        // signed lane patterns
        send(8'h9C, 1'b1);
        cyc();
        send(8'h7A, 1'b1);
        cyc();
        in_v = 1'b0;
        repeat (2) cyc();
        check("lane_sb_empty", 32'(sb_q.size()), 32'd0);

        // random traffic throttled by stall
        for (int c = 0; c < 300; c++) begin
            if (!stall && $urandom_range(0, 1) == 1)
                send(8'($urandom_range(0, 255)), 1'b1);
            else
                in_v = 1'b0;
            m_axis_tready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        in_v = 1'b0;
        m_axis_tready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        cyc();
        check("rand_sb_empty", 32'(sb_q.size()), 32'd0);
        check("rand_overflow", 32'(overflow), 32'd0);
        check("rand_occ", 32'(occupancy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
